// File: rtl/key_db_pkg.sv
// Shared types and constants for the push-button debounce block.
// Holds the per-channel state encoding, the default debounce length and the counter sizing helper.
package key_db_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    // 20 ms of stability at the 12 MHz board clock.
    localparam int DB_CYCLES_DEFAULT = 240000;

    // The counter only has to reach cycles-1, so clog2 is exact; one bit is the floor.
    function automatic int db_cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, stability FSM with counter, press/release pulses and LED toggle.
// Handshake-free: all outputs are plain registered levels or single-cycle pulses, no valid/ready.
module key_debounce_ch
    import key_db_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      key_n,
    output logic      state,
    output logic      press,
    output logic      rel,
    output logic      led_n,
    output db_state_t dbg_state
);

    localparam int CW = db_cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          ks;
    db_state_t     cur;
    db_state_t     nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          press_nxt;
    logic          rel_nxt;

    // Sync flops reset to 1 so a released key looks stable from the first clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            ks    <= 1'b1;
        end else begin
            sync1 <= key_n;
            ks    <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur   <= IDLE;
            cnt   <= '0;
            state <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
            led_n <= 1'b1;
        end else begin
            cur   <= nxt;
            cnt   <= cnt_nxt;
            state <= (nxt == PRESSED) || (nxt == RELEASE_WAIT);
            press <= press_nxt;
            rel   <= rel_nxt;
            led_n <= led_n ^ press_nxt;
        end
    end

    always_comb begin
        nxt       = cur;
        cnt_nxt   = cnt;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        case (cur)
            IDLE: begin
                if (!ks) begin
                    nxt     = PRESS_WAIT;
                    cnt_nxt = '0;
                end
            end
            PRESS_WAIT: begin
                if (ks) begin
                    nxt     = IDLE;
                    cnt_nxt = '0;
                end else if (cnt == CNT_LAST) begin
                    nxt       = PRESSED;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            PRESSED: begin
                if (ks) begin
                    nxt     = RELEASE_WAIT;
                    cnt_nxt = '0;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back to pressed restores PRESSED silently; no second press pulse.
                if (!ks) begin
                    nxt     = PRESSED;
                    cnt_nxt = '0;
                end else if (cnt == CNT_LAST) begin
                    nxt     = IDLE;
                    cnt_nxt = '0;
                    rel_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                nxt     = IDLE;
                cnt_nxt = '0;
            end
        endcase
    end

    assign dbg_state = cur;

endmodule

// File: rtl/key_debounce_led.sv
// Multi-key conditioner: one independent debounce channel per key/LED pair.
// dbg_state packs each channel's FSM state, two bits per channel, channel 0 in the low bits.
module key_debounce_led
    import key_db_pkg::*;
#(
    parameter int KEY_NUM   = 4,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [KEY_NUM-1:0]   key,
    output logic [KEY_NUM-1:0]   key_state,
    output logic [KEY_NUM-1:0]   key_press,
    output logic [KEY_NUM-1:0]   key_release,
    output logic [KEY_NUM-1:0]   led,
    output logic [2*KEY_NUM-1:0] dbg_state
);

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        db_state_t ch_state;

        key_debounce_ch #(
            .DB_CYCLES (DB_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .key_n     (key[i]),
            .state     (key_state[i]),
            .press     (key_press[i]),
            .rel       (key_release[i]),
            .led_n     (led[i]),
            .dbg_state (ch_state)
        );

        assign dbg_state[2*i +: 2] = ch_state;
    end

endmodule

// File: tb/tb_key_debounce_led.sv
// Bench for key_debounce_led with DB_CYCLES=16: expected pulses are queued with their due cycle
// when keys are driven, and every observed pulse is matched against the head of the queue.
module tb_key_debounce_led;

    localparam int KEY_NUM   = 4;
    localparam int DB_CYCLES = 16;
    localparam int LAT       = DB_CYCLES + 3;  // negedge drive -> E is next posedge -> pulse at E+DB+2
    localparam logic [3:0] K_PRESS = 4'd1;
    localparam logic [3:0] K_REL   = 4'd2;

    logic                 clk;
    logic                 rst;
    logic [KEY_NUM-1:0]   key;
    logic [KEY_NUM-1:0]   key_state;
    logic [KEY_NUM-1:0]   key_press;
    logic [KEY_NUM-1:0]   key_release;
    logic [KEY_NUM-1:0]   led;
    logic [2*KEY_NUM-1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [31:0] exp_q[$];

    key_debounce_led #(
        .KEY_NUM   (KEY_NUM),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .led         (led),
        .dbg_state   (dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pack_ev(input int at, input int ch, input logic [3:0] kind);
        logic [31:0] c;
        c = at;
        return {c[23:0], 4'(ch), kind};
    endfunction

    // driver tasks
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_keys(input logic [KEY_NUM-1:0] val, input logic [3:0] kind,
                              input logic [KEY_NUM-1:0] expect_mask);
        key = val;
        for (int ch = 0; ch < KEY_NUM; ch++)
            if (expect_mask[ch]) exp_q.push_back(pack_ev(cyc + LAT, ch, kind));
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [31:0] head;
        logic [31:0] now;
        now = cyc;
        while (exp_q.size() > 0) begin
            head = exp_q[0];
            if (head[31:8] >= now[23:0]) break;
            check("missed_pulse", 32'h0, head);
            void'(exp_q.pop_front());
        end
        for (int ch = 0; ch < KEY_NUM; ch++) begin
            if (key_press[ch]) begin
                if (exp_q.size() == 0) check("unexpected_press", pack_ev(cyc, ch, K_PRESS), 32'h0);
                else check("press_pulse", pack_ev(cyc, ch, K_PRESS), exp_q.pop_front());
            end
            if (key_release[ch]) begin
                if (exp_q.size() == 0) check("unexpected_release", pack_ev(cyc, ch, K_REL), 32'h0);
                else check("release_pulse", pack_ev(cyc, ch, K_REL), exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b0;
        key = 4'b1111;
        wait_cyc(5);
        check("rst_led", 32'(led), 32'hF);
        check("rst_state", 32'(key_state), 32'h0);
        check("rst_pulses", 32'({key_press, key_release}), 32'h0);
        check("rst_fsm", 32'(dbg_state), 32'h0);
        rst = 1'b1;
        wait_cyc(100);
        check("idle_led", 32'(led), 32'hF);
        check("idle_state", 32'(key_state), 32'h0);

        // clean press on key 0
        drive_keys(4'b1110, K_PRESS, 4'b0001);
        wait_cyc(LAT - 1);
        check("pre_press_led0", 32'(led[0]), 32'h1);
        check("pre_press_state0", 32'(key_state[0]), 32'h0);
        wait_cyc(1);
        check("press_led0", 32'(led[0]), 32'h0);
        check("press_state0", 32'(key_state[0]), 32'h1);
        wait_cyc(10);

        // bounce on key 1: 5-clock runs never reach the debounce length
        for (int i = 0; i < 40; i++) begin
            key[1] = ~key[1];
            wait_cyc(5);
            check("bounce_led1", 32'(led[1]), 32'h1);
        end
        key[1] = 1'b1;
        wait_cyc(40);
        check("bounce_state1", 32'(key_state[1]), 32'h0);
        check("bounce_led1_end", 32'(led[1]), 32'h1);

        // release then re-press key 0
        drive_keys(4'b1111, K_REL, 4'b0001);
        wait_cyc(LAT - 1);
        check("pre_rel_state0", 32'(key_state[0]), 32'h1);
        wait_cyc(1);
        check("rel_state0", 32'(key_state[0]), 32'h0);
        check("rel_led0", 32'(led[0]), 32'h0);
        wait_cyc(40 - LAT);
        drive_keys(4'b1110, K_PRESS, 4'b0001);
        wait_cyc(40);
        check("repress_state0", 32'(key_state[0]), 32'h1);
        check("repress_led0", 32'(led[0]), 32'h1);

        drive_keys(4'b1111, K_REL, 4'b0001);
        wait_cyc(40);
        check("all_released_led", 32'(led), 32'hF);

        // simultaneous press on all keys
        drive_keys(4'b0000, K_PRESS, 4'b1111);
        wait_cyc(40);
        check("simul_led", 32'(led), 32'h0);
        check("simul_state", 32'(key_state), 32'hF);
        check("simul_fsm", 32'(dbg_state), 32'hAA);

        drive_keys(4'b1111, K_REL, 4'b1111);
        wait_cyc(40);
        check("simul_rel_state", 32'(key_state), 32'h0);

        // press again, reset 10 clocks into the debounce
        key = 4'b0000;
        wait_cyc(10);
        rst = 1'b0;
        wait_cyc(3);
        check("midrst_led", 32'(led), 32'hF);
        check("midrst_state", 32'(key_state), 32'h0);
        check("midrst_fsm", 32'(dbg_state), 32'h0);
        drive_keys(4'b0000, K_PRESS, 4'b1111);
        rst = 1'b1;
        wait_cyc(LAT - 1);
        check("post_rst_pre_led", 32'(led), 32'hF);
        wait_cyc(1);
        check("post_rst_led", 32'(led), 32'h0);
        check("post_rst_state", 32'(key_state), 32'hF);
        wait_cyc(20);

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
